// File: rtl/cim_ctrl.sv
// -----------------------------------------------------------------------------
// cim_ctrl -- command sequencer for a compute-in-memory PE array.
//
// Accepts one command at a time and drives the PE array:
//   LOAD    : streams ROWS weight beats into consecutive PE rows, starting at
//             cmd_addr and wrapping modulo ROWS. Produces no result.
//   READ    : reads one PE row; the weight is returned zero-extended.
//   COMPUTE : registers the activation vector onto pe_act and captures the
//             PE partial sum one cycle later.
//   op 11   : accepted and dropped.
// READ/COMPUTE results sit in RESULT until res_ready; cmd_ready is low there,
// so a new command can never be accepted in the cycle a result is consumed.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/ready/op/addr    command channel
//   act_data                   activation vector for COMPUTE (ROWS*WW)
//   wt_valid/ready/data        weight stream used during LOAD
//   res_valid/ready/data       result channel (PSUM or zero-extended weight)
//   busy                       high whenever the controller is not idle
//   pe_stdw/pe_stdr            PE write strobe / read select (never both high)
//   pe_std_a                   PE row address (holds when no strobe)
//   pe_weight_in               weight written on pe_stdw
//   pe_act                     registered activations
//   pe_weight_out, pe_psum     PE read data and partial sum
// -----------------------------------------------------------------------------
module cim_ctrl #(
   parameter int ROWS = 64,
   parameter int AW   = 6,
   parameter int WW   = 4,
   parameter int PW   = 14
) (
   input  logic                 clk,
   input  logic                 rst_n,
   // command channel
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [AW-1:0]        cmd_addr,
   input  logic [ROWS*WW-1:0]   act_data,
   // weight stream
   input  logic                 wt_valid,
   output logic                 wt_ready,
   input  logic [WW-1:0]        wt_data,
   // result channel and status
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [PW-1:0]        res_data,
   output logic                 busy,
   // PE side
   output logic                 pe_stdw,
   output logic                 pe_stdr,
   output logic [AW-1:0]        pe_std_a,
   output logic [WW-1:0]        pe_weight_in,
   output logic [ROWS*WW-1:0]   pe_act,
   input  logic [WW-1:0]        pe_weight_out,
   input  logic [PW-1:0]        pe_psum
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_READ,
      S_COMP,
      S_RESULT
   } state_t;

   localparam logic [1:0]    OP_LOAD   = 2'b00;
   localparam logic [1:0]    OP_READ   = 2'b01;
   localparam logic [1:0]    OP_COMP   = 2'b10;
   localparam logic [AW-1:0] LAST_BEAT = AW'(ROWS - 1);

   state_t        state, state_nxt;
   logic [AW-1:0] row_cnt;    // next PE row to write during LOAD
   logic [AW-1:0] beat_cnt;   // beats accepted in the current burst
   logic [AW-1:0] rd_addr;    // row captured by READ
   logic [AW-1:0] addr_hold;  // last address presented with a strobe
   logic          cmd_acc;

   assign cmd_acc = cmd_valid & cmd_ready;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt    = state;
      cmd_ready    = 1'b0;
      wt_ready     = 1'b0;
      res_valid    = 1'b0;
      busy         = 1'b1;
      pe_stdw      = 1'b0;
      pe_stdr      = 1'b0;
      pe_std_a     = addr_hold;
      pe_weight_in = '0;

      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               case (cmd_op)
                  OP_LOAD: state_nxt = S_LOAD;
                  OP_READ: state_nxt = S_READ;
                  OP_COMP: state_nxt = S_COMP;
                  default: state_nxt = S_IDLE;  // reserved op: swallowed
               endcase
            end
         end
         S_LOAD: begin
            wt_ready = 1'b1;
            if (wt_valid) begin
               pe_stdw      = 1'b1;
               pe_std_a     = row_cnt;
               pe_weight_in = wt_data;
               if (beat_cnt == LAST_BEAT) state_nxt = S_IDLE;
            end
         end
         S_READ: begin
            pe_stdr   = 1'b1;
            pe_std_a  = rd_addr;
            state_nxt = S_RESULT;
         end
         S_COMP: begin
            // PE sees stable pe_act with both strobes low for this cycle.
            state_nxt = S_RESULT;
         end
         S_RESULT: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_cnt   <= '0;
         beat_cnt  <= '0;
         rd_addr   <= '0;
         addr_hold <= '0;
         pe_act    <= '0;
         res_data  <= '0;
      end else begin
         if (cmd_acc) begin
            case (cmd_op)
               OP_LOAD: begin
                  row_cnt  <= cmd_addr;
                  beat_cnt <= '0;
               end
               OP_READ: rd_addr <= cmd_addr;
               OP_COMP: pe_act  <= act_data;
               default: ;
            endcase
         end

         // ROWS is a power of two, so the natural AW-bit wrap gives row 63 -> 0.
         if (pe_stdw) begin
            row_cnt  <= row_cnt + AW'(1);
            beat_cnt <= beat_cnt + AW'(1);
         end

         if (pe_stdw || pe_stdr) addr_hold <= pe_std_a;

         if (state == S_READ) res_data <= {{(PW - WW){1'b0}}, pe_weight_out};
         if (state == S_COMP) res_data <= pe_psum;
      end
   end

endmodule

// File: tb/tb_cim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cim_ctrl -- directed bench for cim_ctrl with a behavioural PE array.
// Expected READ/COMPUTE results are queued when the command is driven and
// compared when the DUT hands a result over. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cim_ctrl;

   localparam int ROWS = 64;
   localparam int AW   = 6;
   localparam int WW   = 4;
   localparam int PW   = 14;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                cmd_valid, cmd_ready;
   logic [1:0]          cmd_op;
   logic [AW-1:0]       cmd_addr;
   logic [ROWS*WW-1:0]  act_data;
   logic                wt_valid, wt_ready;
   logic [WW-1:0]       wt_data;
   logic                res_valid, res_ready;
   logic [PW-1:0]       res_data;
   logic                busy;
   logic                pe_stdw, pe_stdr;
   logic [AW-1:0]       pe_std_a;
   logic [WW-1:0]       pe_weight_in;
   logic [ROWS*WW-1:0]  pe_act;
   logic [WW-1:0]       pe_weight_out;
   logic [PW-1:0]       pe_psum;

   int n_cmp = 0;
   int n_err = 0;

   logic [PW-1:0] res_q[$];      // expected results, in order
   logic [WW-1:0] exp_w[ROWS];   // weights the bench intended to write
   logic [WW-1:0] pe_mem[ROWS];  // behavioural PE storage

   always #5 clk = ~clk;

   cim_ctrl #(.ROWS(ROWS), .AW(AW), .WW(WW), .PW(PW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_addr      (cmd_addr),
      .act_data      (act_data),
      .wt_valid      (wt_valid),
      .wt_ready      (wt_ready),
      .wt_data       (wt_data),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_data      (res_data),
      .busy          (busy),
      .pe_stdw       (pe_stdw),
      .pe_stdr       (pe_stdr),
      .pe_std_a      (pe_std_a),
      .pe_weight_in  (pe_weight_in),
      .pe_act        (pe_act),
      .pe_weight_out (pe_weight_out),
      .pe_psum       (pe_psum)
   );

   // ---------------- behavioural PE array ----------------
   always @(posedge clk) begin
      if (pe_stdw === 1'b1) pe_mem[pe_std_a] <= pe_weight_in;
   end

   assign pe_weight_out = pe_mem[pe_std_a];

   always_comb begin : pe_mac
      int s;
      s = 0;
      for (int i = 0; i < ROWS; i++) s += int'(pe_mem[i]) * int'(pe_act[i*WW +: WW]);
      pe_psum = PW'(s);
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WW-1:0] wdat(input int pat, input logic [AW-1:0] r);
      case (pat)
         0:       return r[3:0];
         1:       return 4'hF;
         2:       return ~r[3:0];
         default: return r[3:0] ^ 4'h5;
      endcase
   endfunction

   function automatic logic [PW-1:0] exp_psum(input logic [ROWS*WW-1:0] act);
      int s;
      s = 0;
      for (int i = 0; i < ROWS; i++) s += int'(exp_w[i]) * int'(act[i*WW +: WW]);
      return PW'(s);
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                            input logic [ROWS*WW-1:0] act);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      act_data  = act;
      @(negedge clk);
      check("cmd_ready_idle", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
   endtask

   // LOAD burst; gappy offers a beat only on every other cycle.
   task automatic load_burst(input logic [AW-1:0] start, input int pat,
                             input bit gappy, input int stop_after);
      logic [AW-1:0] row, last_row;
      int beats, cyc;
      bit v;
      issue_cmd(2'b00, start, '0);
      row = start;
      last_row = start;
      beats = 0;
      cyc = 0;
      while (beats < stop_after && cyc < 200) begin
         v = !gappy || (cyc % 2 == 0);
         wt_valid = v;
         wt_data  = wdat(pat, row);
         @(negedge clk);
         check("load_busy", busy, 1'b1);
         check("load_wt_ready", wt_ready, 1'b1);
         check("load_pe_stdw", pe_stdw, v);
         check("load_pe_stdr", pe_stdr, 1'b0);
         if (v) begin
            check("load_pe_std_a", pe_std_a, row);
            check("load_pe_weight_in", pe_weight_in, wt_data);
            exp_w[row] = wt_data;
            last_row = row;
            row = row + 6'd1;
            beats++;
         end else begin
            check("load_addr_hold", pe_std_a, last_row);
         end
         tick();
         cyc++;
      end
      check("load_beats_done", beats, stop_after);
      wt_valid = 1'b0;
   endtask

   // ---------------- result scoreboard ----------------
   always @(negedge clk) begin
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
         if (res_q.size() == 0) check("unexpected_result", res_valid, 1'b0);
         else                   check("res_data", res_data, res_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, observed=running expected=finished");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [ROWS*WW-1:0] ones;
      logic [ROWS*WW-1:0] act_r;
      ones = '1;
      for (int i = 0; i < ROWS / 8; i++) act_r[i*32 +: 32] = $urandom;

      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_addr  = '0;
      act_data  = '0;
      wt_valid  = 1'b0;
      wt_data   = '0;
      res_ready = 1'b1;

      // reset values
      #12;
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_wt_ready", wt_ready, 1'b0);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_res_data", res_data, 14'h0);
      check("rst_pe_stdw", pe_stdw, 1'b0);
      check("rst_pe_stdr", pe_stdr, 1'b0);
      check("rst_pe_std_a", pe_std_a, 6'h0);
      check("rst_pe_weight_in", pe_weight_in, 4'h0);
      check("rst_pe_act", pe_act, '0);
      #1 rst_n = 1'b1;
      tick();

      // full burst from row 0, weight = row % 16
      load_burst(6'd0, 0, 1'b0, 64);
      @(negedge clk);
      check("load0_busy_drop", busy, 1'b0);
      check("load0_wt_ready_drop", wt_ready, 1'b0);
      check("load0_no_stdw", pe_stdw, 1'b0);
      check("load0_addr_hold", pe_std_a, 6'd63);
      tick();

      // burst from row 62 with gaps, all-ones weights (rows 62,63,0..61)
      load_burst(6'd62, 1, 1'b1, 64);
      @(negedge clk);
      check("load62_busy_drop", busy, 1'b0);
      check("load62_addr_hold", pe_std_a, 6'd61);
      tick();

      // COMPUTE with all activations 15 against all-ones weights
      res_q.push_back(14'd14400);
      issue_cmd(2'b10, 6'd0, ones);
      @(negedge clk);
      check("comp_res_valid_early", res_valid, 1'b0);
      check("comp_pe_stdw", pe_stdw, 1'b0);
      check("comp_pe_stdr", pe_stdr, 1'b0);
      check("comp_pe_act", pe_act, ones);
      check("comp_busy", busy, 1'b1);
      tick();
      @(negedge clk);
      check("comp_latency_res_valid", res_valid, 1'b1);
      check("comp_cmd_ready_result", cmd_ready, 1'b0);
      tick();
      @(negedge clk);
      check("comp_res_valid_drop", res_valid, 1'b0);
      check("comp_busy_drop", busy, 1'b0);
      check("comp_pe_act_hold", pe_act, ones);
      tick();

      // reload with weight = ~row so row 5 holds 0xA
      load_burst(6'd0, 2, 1'b0, 64);
      @(negedge clk);
      check("load2_busy_drop", busy, 1'b0);
      tick();

      // READ row 5 with back-pressure for 3 cycles
      res_ready = 1'b0;
      res_q.push_back(14'h000A);
      issue_cmd(2'b01, 6'd5, '0);
      @(negedge clk);
      check("read_pe_stdr", pe_stdr, 1'b1);
      check("read_pe_std_a", pe_std_a, 6'd5);
      check("read_pe_stdw", pe_stdw, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("read_hold_res_valid", res_valid, 1'b1);
         check("read_hold_res_data", res_data, 14'h000A);
         check("read_hold_cmd_ready", cmd_ready, 1'b0);
         check("read_hold_pe_stdr", pe_stdr, 1'b0);
         tick();
      end
      res_ready = 1'b1;
      @(negedge clk);
      check("read_consume_valid", res_valid, 1'b1);
      tick();
      @(negedge clk);
      check("read_res_valid_drop", res_valid, 1'b0);
      check("read_addr_hold", pe_std_a, 6'd5);
      tick();

      // COMPUTE with random activations against the ~row weights
      res_q.push_back(exp_psum(act_r));
      issue_cmd(2'b10, 6'd0, act_r);
      @(negedge clk);
      tick();
      @(negedge clk);
      check("comp2_res_valid", res_valid, 1'b1);
      tick();
      @(negedge clk);
      tick();

      // reserved op: swallowed, nothing happens
      issue_cmd(2'b11, 6'd7, ones);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rsv_pe_stdw", pe_stdw, 1'b0);
         check("rsv_pe_stdr", pe_stdr, 1'b0);
         check("rsv_res_valid", res_valid, 1'b0);
         check("rsv_busy", busy, 1'b0);
         check("rsv_pe_act_hold", pe_act, act_r);
         tick();
      end

      // reset in the middle of a burst after 10 beats
      load_burst(6'd0, 3, 1'b0, 10);
      wt_valid = 1'b1;
      wt_data  = 4'h0;
      #1 rst_n = 1'b0;
      #1;
      check("ldrst_pe_stdw", pe_stdw, 1'b0);
      check("ldrst_wt_ready", wt_ready, 1'b0);
      check("ldrst_busy", busy, 1'b0);
      check("ldrst_cmd_ready", cmd_ready, 1'b1);
      check("ldrst_pe_std_a", pe_std_a, 6'h0);
      check("ldrst_pe_weight_in", pe_weight_in, 4'h0);
      check("ldrst_pe_act", pe_act, '0);
      check("ldrst_res_data", res_data, 14'h0);
      check("ldrst_res_valid", res_valid, 1'b0);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("ldrst_no_strobe", pe_stdw, 1'b0);
         tick();
      end
      wt_valid = 1'b0;

      // row 3 keeps the weight written before the reset (3 ^ 5 = 6)
      res_q.push_back(14'h0006);
      issue_cmd(2'b01, 6'd3, '0);
      @(negedge clk);
      check("rd3_pe_std_a", pe_std_a, 6'd3);
      tick();
      @(negedge clk);
      tick();

      // reset while a result is pending discards it
      res_ready = 1'b0;
      issue_cmd(2'b01, 6'd9, '0);
      @(negedge clk);
      tick();
      @(negedge clk);
      check("rsrst_pending", res_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rsrst_res_valid", res_valid, 1'b0);
      check("rsrst_res_data", res_data, 14'h0);
      check("rsrst_busy", busy, 1'b0);
      res_ready = 1'b1;
      #1 rst_n = 1'b1;
      tick();
      @(negedge clk);
      check("rsrst_no_result", res_valid, 1'b0);
      tick();

      check("scoreboard_empty", res_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
